// File: rtl/terminal_requisicao.sv
// Request terminal for one control-panel input interface: collects a user code and
// a function code, presents them to the panel and reacts to its rejection line.
module terminal_requisicao #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int ERR_CYCLES     = 25_000_000,
  parameter int CNT_W          = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] code_in,
  input  logic       confirm,
  input  logic       cancel,
  input  logic       rejected,
  output logic [2:0] user_out,
  output logic [2:0] func_out,
  output logic       active,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    WAIT_FUNC = 3'b001,
    CHECK     = 3'b010,
    ACTIVE    = 3'b011,
    REJECT    = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_LOAD     = CNT_W'(ERR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;

  state_t           state_q, state_d;
  logic [2:0]       user_r, user_d;
  logic [2:0]       func_r, func_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt == CNT_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      user_r  <= 3'b000;
      func_r  <= 3'b000;
      cnt     <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      user_r  <= user_d;
      func_r  <= func_d;
      cnt     <= cnt_d;
    end
  end

  // Cancel outranks everything outside IDLE, including a simultaneous confirm.
  always_comb begin
    state_d = state_q;
    user_d  = user_r;
    func_d  = func_r;
    cnt_d   = cnt;
    if (cancel && (state_q != IDLE)) begin
      state_d = IDLE;
      user_d  = 3'b000;
      func_d  = 3'b000;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (confirm) begin
            user_d  = code_in;
            cnt_d   = TIMEOUT_LOAD;
            state_d = WAIT_FUNC;
          end
        end
        WAIT_FUNC: begin
          if (confirm) begin
            func_d  = code_in;
            state_d = CHECK;
          end else if (cnt_zero) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt - CNT_ONE;
          end
        end
        CHECK: begin
          if (rejected) begin
            cnt_d   = ERR_LOAD;
            state_d = REJECT;
          end else begin
            cnt_d   = HOLD_LOAD;
            state_d = ACTIVE;
          end
        end
        ACTIVE, REJECT: begin
          if (cnt_zero) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          user_d  = 3'b000;
          func_d  = 3'b000;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Codes reach the panel only while its verdict is being formed or is in force.
  always_comb begin
    user_out = 3'b000;
    func_out = 3'b000;
    active   = 1'b0;
    error    = 1'b0;
    case (state_q)
      CHECK: begin
        user_out = user_r;
        func_out = func_r;
      end
      ACTIVE: begin
        user_out = user_r;
        func_out = func_r;
        active   = 1'b1;
      end
      REJECT: error = 1'b1;
      default: begin
        user_out = 3'b000;
        func_out = 3'b000;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_terminal_requisicao.sv
// Directed self-checking bench: two terminals (IE1/IE2) with short hold/timeout/error windows.
module tb_terminal_requisicao;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] code_a, code_b;
  logic       confirm_a, confirm_b, cancel_a, cancel_b, rej_a, rej_b;
  logic [2:0] user_a, func_a, state_a, user_b, func_b, state_b;
  logic       active_a, error_a, active_b, error_b;
  logic [10:0] obs_a, obs_b;

  int total = 0;
  int bad   = 0;

  localparam logic [10:0] IDLE_V = 11'b000_000_000_0_0;

  always #5 clk = ~clk;

  terminal_requisicao #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(6), .ERR_CYCLES(3), .CNT_W(4)) u_ie1 (
    .clk(clk), .reset(reset), .code_in(code_a), .confirm(confirm_a), .cancel(cancel_a),
    .rejected(rej_a), .user_out(user_a), .func_out(func_a), .active(active_a),
    .error(error_a), .state(state_a)
  );

  terminal_requisicao #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(6), .ERR_CYCLES(3), .CNT_W(4)) u_ie2 (
    .clk(clk), .reset(reset), .code_in(code_b), .confirm(confirm_b), .cancel(cancel_b),
    .rejected(rej_b), .user_out(user_b), .func_out(func_b), .active(active_b),
    .error(error_b), .state(state_b)
  );

  // Observation vector: {state, user_out, func_out, active, error}
  assign obs_a = {state_a, user_a, func_a, active_a, error_a};
  assign obs_b = {state_b, user_b, func_b, active_b, error_b};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    code_a = 3'b000; code_b = 3'b000;
    confirm_a = 1'b0; confirm_b = 1'b0;
    cancel_a = 1'b0; cancel_b = 1'b0;
    rej_a = 1'b0; rej_b = 1'b0;
    step();
    step();
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL reset_a got=%b want=%b", obs_a, IDLE_V);
    end
    total++;
    if (obs_b !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL reset_b got=%b want=%b", obs_b, IDLE_V);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_accept();
    logic [10:0] exp_v;
    rej_a = 1'b0;
    code_a = 3'b011; confirm_a = 1'b1;
    step();
    code_a = 3'b101;
    exp_v = {3'b001, 3'b000, 3'b000, 1'b0, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL accept_wait got=%b want=%b", obs_a, exp_v);
    end
    step();
    confirm_a = 1'b0;
    exp_v = {3'b010, 3'b011, 3'b101, 1'b0, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL accept_check got=%b want=%b", obs_a, exp_v);
    end
    exp_v = {3'b011, 3'b011, 3'b101, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs_a !== exp_v) begin
        bad++;
        $display("[TB] FAIL accept_active[%0d] got=%b want=%b", i, obs_a, exp_v);
      end
    end
    step();
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL accept_idle got=%b want=%b", obs_a, IDLE_V);
    end
  endtask

  task automatic test_reject();
    logic [10:0] exp_v;
    rej_a = 1'b1;
    code_a = 3'b011; confirm_a = 1'b1;
    step();
    code_a = 3'b101;
    step();
    confirm_a = 1'b0;
    exp_v = {3'b010, 3'b011, 3'b101, 1'b0, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL reject_check got=%b want=%b", obs_a, exp_v);
    end
    exp_v = {3'b100, 3'b000, 3'b000, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_a !== exp_v) begin
        bad++;
        $display("[TB] FAIL reject_err[%0d] got=%b want=%b", i, obs_a, exp_v);
      end
    end
    step();
    rej_a = 1'b0;
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL reject_idle got=%b want=%b", obs_a, IDLE_V);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] exp_v;
    exp_v = {3'b001, 3'b000, 3'b000, 1'b0, 1'b0};
    code_a = 3'b010; confirm_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      confirm_a = 1'b0;
      total++;
      if (obs_a !== exp_v) begin
        bad++;
        $display("[TB] FAIL timeout_wait[%0d] got=%b want=%b", i, obs_a, exp_v);
      end
    end
    step();
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL timeout_idle got=%b want=%b", obs_a, IDLE_V);
    end
    // Second pass: confirm lands in the last waiting cycle and must beat the timeout.
    code_a = 3'b010; confirm_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      confirm_a = 1'b0;
      if (i == 5) begin
        code_a = 3'b110;
        confirm_a = 1'b1;
      end
    end
    step();
    confirm_a = 1'b0;
    exp_v = {3'b010, 3'b010, 3'b110, 1'b0, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL timeout_last_confirm got=%b want=%b", obs_a, exp_v);
    end
    cancel_a = 1'b1;
    step();
    cancel_a = 1'b0;
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL cancel_in_check got=%b want=%b", obs_a, IDLE_V);
    end
  endtask

  task automatic test_cancel();
    logic [10:0] exp_v;
    rej_a = 1'b0;
    code_a = 3'b011; confirm_a = 1'b1;
    step();
    code_a = 3'b101;
    step();
    confirm_a = 1'b0;
    step();
    confirm_a = 1'b1; cancel_a = 1'b1; code_a = 3'b111;
    step();
    confirm_a = 1'b0; cancel_a = 1'b0;
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL cancel_active got=%b want=%b", obs_a, IDLE_V);
    end
    cancel_a = 1'b1;
    step();
    cancel_a = 1'b0;
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL cancel_idle got=%b want=%b", obs_a, IDLE_V);
    end
    code_a = 3'b001; confirm_a = 1'b1; cancel_a = 1'b1;
    step();
    confirm_a = 1'b0; cancel_a = 1'b0;
    exp_v = {3'b001, 3'b000, 3'b000, 1'b0, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL cancel_ignored_idle got=%b want=%b", obs_a, exp_v);
    end
    cancel_a = 1'b1;
    step();
    cancel_a = 1'b0;
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL cancel_wait got=%b want=%b", obs_a, IDLE_V);
    end
    // After a cancel the held user code must be gone: a fresh request shows only the new codes.
    code_a = 3'b100; confirm_a = 1'b1;
    step();
    code_a = 3'b010;
    step();
    confirm_a = 1'b0;
    exp_v = {3'b010, 3'b100, 3'b010, 1'b0, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL cancel_fresh_check got=%b want=%b", obs_a, exp_v);
    end
    cancel_a = 1'b1;
    step();
    cancel_a = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [10:0] exp_v;
    rej_a = 1'b0;
    code_a = 3'b011; confirm_a = 1'b1;
    step();
    code_a = 3'b101;
    step();
    confirm_a = 1'b0;
    step();
    exp_v = {3'b011, 3'b011, 3'b101, 1'b1, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL areset_pre got=%b want=%b", obs_a, exp_v);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs_a !== IDLE_V) begin
      bad++;
      $display("[TB] FAIL areset_immediate got=%b want=%b", obs_a, IDLE_V);
    end
    step();
    reset = 1'b0;
    code_a = 3'b110; confirm_a = 1'b1;
    step();
    code_a = 3'b001;
    step();
    confirm_a = 1'b0;
    exp_v = {3'b010, 3'b110, 3'b001, 1'b0, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL areset_after got=%b want=%b", obs_a, exp_v);
    end
    step();
    exp_v = {3'b011, 3'b110, 3'b001, 1'b1, 1'b0};
    total++;
    if (obs_a !== exp_v) begin
      bad++;
      $display("[TB] FAIL areset_after_active got=%b want=%b", obs_a, exp_v);
    end
    cancel_a = 1'b1;
    step();
    cancel_a = 1'b0;
  endtask

  task automatic test_two_instances();
    logic [10:0] exp_a, exp_b;
    rej_a = 1'b0; rej_b = 1'b1;
    code_a = 3'b001; code_b = 3'b110;
    confirm_a = 1'b1; confirm_b = 1'b1;
    step();
    code_a = 3'b100; code_b = 3'b100;
    step();
    confirm_a = 1'b0; confirm_b = 1'b0;
    exp_a = {3'b010, 3'b001, 3'b100, 1'b0, 1'b0};
    exp_b = {3'b010, 3'b110, 3'b100, 1'b0, 1'b0};
    total++;
    if (obs_a !== exp_a) begin
      bad++;
      $display("[TB] FAIL dual_check_a got=%b want=%b", obs_a, exp_a);
    end
    total++;
    if (obs_b !== exp_b) begin
      bad++;
      $display("[TB] FAIL dual_check_b got=%b want=%b", obs_b, exp_b);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      confirm_a = 1'b0; confirm_b = 1'b0;
      exp_a = (i < 4) ? {3'b011, 3'b001, 3'b100, 1'b1, 1'b0} : IDLE_V;
      exp_b = (i < 3) ? {3'b100, 3'b000, 3'b000, 1'b0, 1'b1} : IDLE_V;
      total++;
      if (obs_a !== exp_a) begin
        bad++;
        $display("[TB] FAIL dual_a[%0d] got=%b want=%b", i, obs_a, exp_a);
      end
      total++;
      if (obs_b !== exp_b) begin
        bad++;
        $display("[TB] FAIL dual_b[%0d] got=%b want=%b", i, obs_b, exp_b);
      end
      if (i == 0 || i == 1) begin
        code_a = 3'b111; code_b = 3'b011;
        confirm_a = 1'b1; confirm_b = 1'b1;
      end
    end
    rej_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_accept();
    test_reject();
    test_timeout();
    test_cancel();
    test_async_reset();
    test_two_instances();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
